// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared constants, ALU op codes and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int IDX_W  = 3;

  // ALU operation codes
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] NOT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 16-bit ALU: add, subtract, bitwise and, invert B; zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu (
  input  logic [15:0] Ain,
  input  logic [15:0] Bin,
  input  logic [1:0]  ALUop,
  output logic [15:0] out,
  output logic        Z
);

  // Select the operation; carry and borrow fall off the top bit.
  always_comb begin
    out = 16'h0000;
    case (ALUop)
      2'b00:   out = Ain + Bin;
      2'b01:   out = Ain - Bin;
      2'b10:   out = Ain & Bin;
      default: out = ~Bin;
    endcase
  end

  assign Z = (out == 16'h0000);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_regfile
// Description : NREGS x DATA_W register file, one synchronous write port,
//               combinational operand and debug read ports, async clear.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] r_mem [NREGS];

  // Storage: cleared asynchronously, written on the commit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata    = r_mem[raddr];
  assign dbg_data = r_mem[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle command sequencer driving the ALU from a small
//               register file (load-immediate and two-operand ALU commands).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [1:0]        cmd_alu_op,
  input  logic [2:0]        cmd_rd,
  input  logic [2:0]        cmd_rn,
  input  logic [2:0]        cmd_rm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              status_z,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  import alu_sequencer_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_rd;
  logic [IDX_W-1:0]  r_rn;
  logic [IDX_W-1:0]  r_rm;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic              r_z;
  logic [IDX_W-1:0]  w_raddr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_alu_out;
  logic              w_alu_z;
  logic              w_accept;
  logic              w_we;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_we      = (r_state == S_WRITE);
  // One shared operand port: rm is needed only while loading B.
  assign w_raddr   = (r_state == S_LOAD_B) ? r_rm : r_rn;

  assign cmd_ready = (r_state == S_IDLE);
  assign done      = w_we;
  assign result    = r_c;
  assign status_z  = r_z;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_state_nxt = cmd_load ? S_WRITE : S_LOAD_A;
      S_LOAD_A: w_state_nxt = S_LOAD_B;
      S_LOAD_B: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = S_WRITE;
      S_WRITE:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Command capture and operand/result staging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd <= '0;
      r_rn <= '0;
      r_rm <= '0;
      r_op <= ADD;
      r_a  <= '0;
      r_b  <= '0;
      r_c  <= '0;
      r_z  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd <= cmd_rd;
        r_rn <= cmd_rn;
        r_rm <= cmd_rm;
        r_op <= cmd_alu_op;
        // Loads bypass the ALU; C is ready for the WRITE cycle directly.
        if (cmd_load) r_c <= cmd_imm;
      end
      if (r_state == S_LOAD_A) r_a <= w_rdata;
      if (r_state == S_LOAD_B) r_b <= w_rdata;
      if (r_state == S_EXEC) begin
        r_c <= w_alu_out;
        r_z <= w_alu_z;
      end
    end
  end

  alu u_alu (
    .Ain   (r_a),
    .Bin   (r_b),
    .ALUop (r_op),
    .out   (w_alu_out),
    .Z     (w_alu_z)
  );

  alu_sequencer_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (w_we),
    .waddr    (r_rd),
    .wdata    (r_c),
    .raddr    (w_raddr),
    .rdata    (w_rdata),
    .dbg_addr (dbg_sel),
    .dbg_data (dbg_data)
  );

endmodule
`default_nettype wire
